reflex_round_sequencer: RTL and testbench
=========================================

// Module: reflex_round_sequencer
// PURPOSE
//  Sequences a multi-round reflex test around the push-button/LED/7-seg datapath.
//  Each round runs: random delay -> stimulus LED -> millisecond timing of the fire press.
//  Tracks last, best and average reaction times, and detects false starts and timeouts.
//  Sits between the debounced button pulses and the LED driver / seven-segment mux.
// PARAMETERS
//  CLKS_PER_MS   100000  clk cycles per 1 ms tick (100 MHz); use 4 in simulation
//  MIN_DELAY_MS  1000    fixed part of the random stimulus delay, ms
//  TIMEOUT_MS    2000    reaction window; a round with no fire press scores TIMEOUT_MS
//  ROUNDS_LOG2   2       rounds per session = 2**ROUNDS_LOG2 (4)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  ready_pulse  in   1   debounced 1-cycle pulse: start session / next round
//  fire_pulse   in   1   debounced 1-cycle pulse: player response
//  abort        in   1   level; while high, forces IDLE (session discarded)
//  stim_led     out  1   stimulus lamp, high only in REACT
//  last_ms      out  12  reaction time of most recent round, ms
//  best_ms      out  12  minimum valid reaction time this session, 12'hFFF if none
//  avg_ms       out  12  session average, valid when done=1
//  round_idx    out  ROUNDS_LOG2  current round number, 0-based
//  false_start  out  1   sticky for the current round: fire pressed before stimulus
//  busy         out  1   high in ARM/WAIT/REACT
//  done         out  1   high in DONE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except best_ms=12'hFFF; LFSR=16'hACE1; prescaler=0.
//  ms tick: prescaler counts 0..CLKS_PER_MS-1; tick=1 for one cycle at wrap; free-running.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every clk; never all-zero.
//  States:
//   IDLE   : ready_pulse -> ARM with round_idx=0, sum=0, best=FFF.
//   ARM    : one cycle; delay_ms <= MIN_DELAY_MS + lfsr[9:0]; ms_cnt<=0;
//            false_start<=0 -> WAIT.
//   WAIT   : ms_cnt++ on tick; fire_pulse -> false_start=1, last_ms=TIMEOUT_MS -> RESULT;
//            ms_cnt==delay_ms -> REACT with ms_cnt<=0.
//   REACT  : stim_led=1; ms_cnt++ on tick; fire_pulse -> last_ms=ms_cnt -> RESULT;
//            ms_cnt==TIMEOUT_MS -> last_ms=TIMEOUT_MS -> RESULT.
//   RESULT : one cycle; sum += last_ms; best=min(best,last_ms) only if not false_start
//            and last_ms<TIMEOUT_MS; then if round_idx==ROUNDS-1 -> DONE,
//            else wait for ready_pulse -> round_idx++ -> ARM (HOLD substate).
//   DONE   : avg_ms = sum >> ROUNDS_LOG2 (sum is 12+ROUNDS_LOG2 bits, no overflow);
//            outputs hold; ready_pulse -> new session as from IDLE.
//  Latency: fire_pulse in REACT to last_ms update = 1 clk; stim_led falls same edge.
//  fire_pulse and ms_cnt reaching its limit in the same cycle: fire_pulse wins.
//  fire_pulse in IDLE/RESULT/HOLD/DONE ignored; ready_pulse in ARM/WAIT/REACT ignored.
//  abort or reset mid-round: next cycle IDLE, stim_led=0, busy=0; registered stats keep
//   values on abort, cleared only by reset or new session start.
//  ms_cnt 12 bits; MIN_DELAY_MS+1023 must fit 12 bits (checked by assertion).
// TESTING (CLKS_PER_MS=4, MIN_DELAY_MS=10, TIMEOUT_MS=50, ROUNDS_LOG2=2)
//  1. reset, ready, fire 7 ticks after stim_led rises -> last_ms=7, best_ms=7, round_idx=0.
//  2. full session fires at 5,9,3,11 ms -> done=1, best_ms=3, avg_ms=7.
//  3. fire during WAIT -> false_start=1, last_ms=50, best_ms unchanged, stim_led never high.
//  4. no fire in REACT -> after 50 ticks last_ms=50, state RESULT, best_ms unchanged.
//  5. abort high mid-WAIT and mid-REACT -> IDLE next clk, stim_led=0, busy=0.
//  6. fire_pulse coincident with ms_cnt==50 -> last_ms=50 recorded as press (fire wins).

Source files
------------

// File: rtl/reflex_round_sequencer.sv
// Reflex round sequencer.
// Runs a multi-round reaction test: random delay, stimulus lamp, then millisecond
// timing of the fire press. Keeps last, best and average reaction times per session,
// and flags false starts (press before the lamp) and timeouts (no press in the window).

// Run-time and parameter checks for the sequencer.
module reflex_round_sequencer_chk #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int TIMEOUT_MS   = 2000
) (
  input logic        clk,
  input logic        reset,
  input logic [15:0] lfsr,
  input logic        stim_led,
  input logic        busy
);

  // Range limits of the 12-bit ms counter, LFSR liveness and lamp/busy consistency.
  always_ff @(posedge clk) begin
    assert (MIN_DELAY_MS + 32'sd1023 <= 32'sd4095)
      else $error("MIN_DELAY_MS + 1023 does not fit the 12-bit ms counter");
    assert (TIMEOUT_MS <= 32'sd4095)
      else $error("TIMEOUT_MS does not fit the 12-bit ms counter");
    if (!reset) begin
      assert (lfsr != 16'h0000) else $error("LFSR reached the all-zero lock-up state");
      assert (!stim_led || busy) else $error("stim_led high while no round is running");
    end
  end

endmodule

module reflex_round_sequencer #(
  parameter int CLKS_PER_MS  = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int TIMEOUT_MS   = 2000,
  parameter int ROUNDS_LOG2  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ready_pulse,
  input  logic                   fire_pulse,
  input  logic                   abort,
  output logic                   stim_led,
  output logic [11:0]            last_ms,
  output logic [11:0]            best_ms,
  output logic [11:0]            avg_ms,
  output logic [ROUNDS_LOG2-1:0] round_idx,
  output logic                   false_start,
  output logic                   busy,
  output logic                   done
);

  localparam int PRESC_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int SUM_W   = 12 + ROUNDS_LOG2;

  localparam logic [PRESC_W-1:0]     PRESC_MAX  = PRESC_W'(CLKS_PER_MS - 1);
  localparam logic [11:0]            MIN_DELAY  = 12'(MIN_DELAY_MS);
  localparam logic [11:0]            TIMEOUT    = 12'(TIMEOUT_MS);
  localparam logic [11:0]            BEST_NONE  = 12'hFFF;
  localparam logic [ROUNDS_LOG2-1:0] LAST_ROUND = ROUNDS_LOG2'((1 << ROUNDS_LOG2) - 1);
  localparam logic [ROUNDS_LOG2-1:0] ROUND_ONE  = ROUNDS_LOG2'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_WAIT   = 3'd2,
    S_REACT  = 3'd3,
    S_RESULT = 3'd4,
    S_HOLD   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                 state_r;
  logic [PRESC_W-1:0]     presc_r;
  logic [15:0]            lfsr_r;
  logic [11:0]            ms_cnt_r;
  logic [11:0]            delay_ms_r;
  logic [SUM_W-1:0]       sum_r;
  logic [SUM_W-1:0]       sum_next_s;
  logic                   tick_s;
  logic                   stim_led_r;
  logic [11:0]            last_ms_r;
  logic [11:0]            best_ms_r;
  logic [11:0]            avg_ms_r;
  logic [ROUNDS_LOG2-1:0] round_idx_r;
  logic                   false_start_r;
  logic                   busy_r;
  logic                   done_r;

  // Feedback bit for the x^16 + x^14 + x^13 + x^11 + 1 Fibonacci LFSR.
  function automatic logic lfsr_feedback(input logic [15:0] value);
    return value[15] ^ value[13] ^ value[12] ^ value[10];
  endfunction

  // Smaller of two 12-bit reaction times.
  function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
    return (a < b) ? a : b;
  endfunction

  assign tick_s = (presc_r == PRESC_MAX);

  // Running session sum including the round being scored this cycle.
  always_comb begin
    sum_next_s = sum_r + SUM_W'(last_ms_r);
  end

  // Free-running millisecond prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= {PRESC_W{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PRESC_W{1'b0}};
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  // Free-running random source for the stimulus delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
    end
  end

  // Round/session state machine with all outputs registered on the transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      ms_cnt_r      <= 12'd0;
      delay_ms_r    <= 12'd0;
      sum_r         <= {SUM_W{1'b0}};
      stim_led_r    <= 1'b0;
      last_ms_r     <= 12'd0;
      best_ms_r     <= BEST_NONE;
      avg_ms_r      <= 12'd0;
      round_idx_r   <= {ROUNDS_LOG2{1'b0}};
      false_start_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else if (abort) begin
      // Session is dropped; the statistics stay visible until the next session.
      state_r    <= S_IDLE;
      stim_led_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (ready_pulse) begin
            state_r     <= S_ARM;
            round_idx_r <= {ROUNDS_LOG2{1'b0}};
            sum_r       <= {SUM_W{1'b0}};
            best_ms_r   <= BEST_NONE;
            last_ms_r   <= 12'd0;
            avg_ms_r    <= 12'd0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
          end
        end
        S_ARM: begin
          delay_ms_r    <= MIN_DELAY + {2'b00, lfsr_r[9:0]};
          ms_cnt_r      <= 12'd0;
          false_start_r <= 1'b0;
          state_r       <= S_WAIT;
        end
        S_WAIT: begin
          if (fire_pulse) begin
            false_start_r <= 1'b1;
            last_ms_r     <= TIMEOUT;
            busy_r        <= 1'b0;
            state_r       <= S_RESULT;
          end else if (ms_cnt_r == delay_ms_r) begin
            ms_cnt_r   <= 12'd0;
            stim_led_r <= 1'b1;
            state_r    <= S_REACT;
          end else if (tick_s) begin
            ms_cnt_r <= ms_cnt_r + 12'd1;
          end
        end
        S_REACT: begin
          // A press on the same cycle as the window closing still counts as a press.
          if (fire_pulse) begin
            last_ms_r  <= ms_cnt_r;
            stim_led_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= S_RESULT;
          end else if (ms_cnt_r == TIMEOUT) begin
            last_ms_r  <= TIMEOUT;
            stim_led_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= S_RESULT;
          end else if (tick_s) begin
            ms_cnt_r <= ms_cnt_r + 12'd1;
          end
        end
        S_RESULT: begin
          sum_r <= sum_next_s;
          if (!false_start_r && (last_ms_r < TIMEOUT)) begin
            best_ms_r <= min12(best_ms_r, last_ms_r);
          end
          if (round_idx_r == LAST_ROUND) begin
            avg_ms_r <= sum_next_s[SUM_W-1:ROUNDS_LOG2];
            done_r   <= 1'b1;
            state_r  <= S_DONE;
          end else begin
            state_r <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (ready_pulse) begin
            round_idx_r <= round_idx_r + ROUND_ONE;
            busy_r      <= 1'b1;
            state_r     <= S_ARM;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          stim_led_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign stim_led    = stim_led_r;
  assign last_ms     = last_ms_r;
  assign best_ms     = best_ms_r;
  assign avg_ms      = avg_ms_r;
  assign round_idx   = round_idx_r;
  assign false_start = false_start_r;
  assign busy        = busy_r;
  assign done        = done_r;

  reflex_round_sequencer_chk #(
    .MIN_DELAY_MS (MIN_DELAY_MS),
    .TIMEOUT_MS   (TIMEOUT_MS)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .lfsr     (lfsr_r),
    .stim_led (stim_led_r),
    .busy     (busy_r)
  );

endmodule

// File: tb/tb_reflex_round_sequencer.sv
// Scoreboard bench for reflex_round_sequencer: the driver plays rounds and queues the
// expected observable events; a monitor pops and compares on every DUT output event.
module tb_reflex_round_sequencer;

  localparam int CPM   = 4;
  localparam int MIN_D = 10;
  localparam int TMO   = 50;
  localparam int NR    = 4;

  localparam int K_ARM = 0, K_ROUND = 1, K_ABORT = 2, K_DONE = 3;
  localparam int A_REACT = 0, A_FALSE = 1, A_ABORT_WAIT = 2, A_ABORT_REACT = 3;

  logic clk = 1'b0, reset = 1'b1, ready_pulse = 1'b0, fire_pulse = 1'b0, abort = 1'b0;
  logic stim_led, false_start, busy, done;
  logic [11:0] last_ms, best_ms, avg_ms;
  logic [1:0] round_idx;

  reflex_round_sequencer #(
    .CLKS_PER_MS(CPM), .MIN_DELAY_MS(MIN_D), .TIMEOUT_MS(TMO), .ROUNDS_LOG2(2)
  ) dut (
    .clk(clk), .reset(reset), .ready_pulse(ready_pulse), .fire_pulse(fire_pulse),
    .abort(abort), .stim_led(stim_led), .last_ms(last_ms), .best_ms(best_ms),
    .avg_ms(avg_ms), .round_idx(round_idx), .false_start(false_start),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Time base and random source as defined for the block, tracked cycle by cycle.
  int unsigned cyc = 0;
  int          presc_m = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      presc_m <= 0;
      lfsr_m  <= 16'hACE1;
    end else begin
      presc_m <= (presc_m == CPM - 1) ? 0 : presc_m + 1;
      lfsr_m  <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  typedef struct {
    int kind; int last; int fs; int idx; int best_pre; int best_post; int avg; int stim_ok;
  } exp_t;
  exp_t q[$];

  // Session model
  int m_sum = 0, m_best = 4095, m_idx = 0, m_last = 0;

  // ---------------- monitor ----------------
  bit   mon_en = 1'b0;
  logic p_busy = 1'b0, p_done = 1'b0, p_stim = 1'b0;
  bit   pend_best = 1'b0;
  int   pend_best_val = 0;
  int   stim_ok_cur = 0;
  int unsigned arm_cyc = 0;
  int   exp_delay = 0;
  int   wlen;
  exp_t me;
  bit   mok;

  task automatic sb_pop(output exp_t e, output bit ok);
    e = '{default: 0};
    check("scoreboard_pending", int'(q.size() > 0), 1);
    ok = (q.size() > 0);
    if (ok) e = q.pop_front();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_best) begin
        check("best_after_result", best_ms, pend_best_val);
        pend_best = 1'b0;
      end
      if (busy && !p_busy) begin
        sb_pop(me, mok);
        if (mok) begin
          check("arm_kind", me.kind, K_ARM);
          check("arm_round_idx", round_idx, me.idx);
          check("arm_best", best_ms, me.best_pre);
          check("arm_done_low", done, 0);
          stim_ok_cur = me.stim_ok;
        end
        arm_cyc   = cyc;
        exp_delay = MIN_D + int'(lfsr_m[9:0]);
      end
      if (stim_led && !p_stim) begin
        check("stim_allowed_this_round", stim_ok_cur, 1);
        wlen = int'(cyc - arm_cyc);
        n_checks++;
        if (wlen < 4 * exp_delay - 1 || wlen > 4 * exp_delay + 2) begin
          n_fail++;
          $display("FAIL wait_length: got %0d cycles, expected %0d..%0d (delay %0d ms)",
                   wlen, 4 * exp_delay - 1, 4 * exp_delay + 2, exp_delay);
        end
      end
      if (!busy && p_busy) begin
        sb_pop(me, mok);
        if (mok) begin
          check("end_kind_round_or_abort", int'(me.kind == K_ROUND || me.kind == K_ABORT), 1);
          check("end_last_ms", last_ms, me.last);
          check("end_false_start", false_start, me.fs);
          check("end_round_idx", round_idx, me.idx);
          check("end_best_before_update", best_ms, me.best_pre);
          check("end_stim_low", stim_led, 0);
          pend_best     = 1'b1;
          pend_best_val = me.best_post;
        end
      end
      if (done && !p_done) begin
        sb_pop(me, mok);
        if (mok) begin
          check("done_kind", me.kind, K_DONE);
          check("done_avg_ms", avg_ms, me.avg);
          check("done_best_ms", best_ms, me.best_post);
          check("done_busy_low", busy, 0);
        end
      end
    end
    p_busy = busy;
    p_done = done;
    p_stim = stim_led;
  end

  // ---------------- driver ----------------
  task automatic pulse_ready();
    ready_pulse = 1'b1; @(negedge clk); ready_pulse = 1'b0;
  endtask
  task automatic pulse_fire();
    fire_pulse = 1'b1; @(negedge clk); fire_pulse = 1'b0;
  endtask
  task automatic pulse_abort();
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  task automatic wait_stim(output bit ok);
    int n = 0;
    while (!stim_led && n < 4400) begin @(negedge clk); n++; end
    ok = stim_led;
    check("stim_rises_in_time", int'(stim_led), 1);
  endtask

  task automatic wait_busy_low();
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    check("round_ends_in_time", int'(busy), 0);
  endtask

  task automatic start_session();
    m_sum = 0; m_best = 4095; m_idx = 0; m_last = 0;
  endtask

  task automatic do_round(input int act, input int k, input bit first);
    exp_t e;
    int   exp_last, ticks, n, stim_ok;
    bit   ok;
    if (!first) m_idx++;
    stim_ok = (act == A_REACT || act == A_ABORT_REACT) ? 1 : 0;
    e = '{default: 0};
    e.kind = K_ARM; e.idx = m_idx; e.best_pre = m_best; e.stim_ok = stim_ok;
    q.push_back(e);
    e = '{default: 0};
    e.idx = m_idx; e.best_pre = m_best;
    if (act == A_ABORT_WAIT || act == A_ABORT_REACT) begin
      e.kind = K_ABORT; e.last = m_last; e.fs = 0; e.best_post = m_best;
      q.push_back(e);
    end else begin
      exp_last = (act == A_FALSE || k >= TMO) ? TMO : k;
      e.kind = K_ROUND; e.last = exp_last; e.fs = (act == A_FALSE) ? 1 : 0;
      m_last = exp_last;
      m_sum += exp_last;
      if (act != A_FALSE && exp_last < TMO && exp_last < m_best) m_best = exp_last;
      e.best_post = m_best;
      q.push_back(e);
      if (m_idx == NR - 1) begin
        e = '{default: 0};
        e.kind = K_DONE; e.avg = m_sum / NR; e.best_post = m_best;
        q.push_back(e);
      end
    end
    // A stray press between rounds must be ignored.
    if ($urandom_range(0, 2) == 0) begin pulse_fire(); @(negedge clk); end
    pulse_ready();
    // A stray ready during the round must be ignored.
    if ($urandom_range(0, 1) == 1) begin @(negedge clk); pulse_ready(); end
    case (act)
      A_FALSE: begin
        repeat ($urandom_range(1, 25)) @(negedge clk);
        pulse_fire();
      end
      A_ABORT_WAIT: begin
        repeat ($urandom_range(1, 25)) @(negedge clk);
        pulse_abort();
      end
      A_ABORT_REACT: begin
        wait_stim(ok);
        if (ok) begin
          repeat ($urandom_range(0, 60)) @(negedge clk);
          pulse_abort();
        end
      end
      default: begin
        wait_stim(ok);
        ticks = 0; n = 0;
        while (ok && stim_led && n < 300) begin
          if (k <= TMO && ticks == k) begin pulse_fire(); break; end
          if (presc_m == CPM - 1) ticks++;
          @(negedge clk); n++;
        end
      end
    endcase
    wait_busy_low();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #950000;
    n_fail++;
    $display("FAIL watchdog: got no completion, expected finish within 95000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act;
    repeat (3) @(negedge clk);
    check("reset_stim_led", stim_led, 0);
    check("reset_last_ms", last_ms, 0);
    check("reset_best_ms", best_ms, 12'hFFF);
    check("reset_avg_ms", avg_ms, 0);
    check("reset_round_idx", round_idx, 0);
    check("reset_false_start", false_start, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Session 1: press 7 ms after the lamp, then abort during the next delay.
    start_session();
    do_round(A_REACT, 7, 1'b1);
    do_round(A_ABORT_WAIT, 0, 1'b0);
    pulse_fire();
    repeat (2) @(negedge clk);
    check("idle_ignores_fire", busy, 0);
    check("abort_keeps_last_ms", last_ms, 7);

    // Session 2: presses at 5, 9, 3, 11 ms.
    start_session();
    do_round(A_REACT, 5, 1'b1);
    do_round(A_REACT, 9, 1'b0);
    do_round(A_REACT, 3, 1'b0);
    do_round(A_REACT, 11, 1'b0);

    // Session 3 from DONE: false start, timeout, press on the window edge, abort in REACT.
    start_session();
    do_round(A_FALSE, 0, 1'b1);
    do_round(A_REACT, 99, 1'b0);
    do_round(A_REACT, TMO, 1'b0);
    do_round(A_ABORT_REACT, 0, 1'b0);

    // Randomised sessions.
    for (int s = 0; s < 2; s++) begin
      start_session();
      for (int r = 0; r < NR; r++) begin
        act = ($urandom_range(0, 99) < 15) ? A_FALSE : A_REACT;
        do_round(act, int'($urandom_range(0, 55)), (r == 0));
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
